mem_port_arbiter: RTL

//  Shares one single-ported, variable-latency memory between instruction fetch (F stage) and

---
 rtl/mem_port_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency memory port between instruction fetch and data access,
// sequencing each access IDLE -> ACCESS -> RESP and stalling the pipeline while requests wait.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        dm_read,
  input  logic        dm_write,
  input  logic        dm_byte,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        stall,
  output logic        err_timeout
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic {GRANT_DATA, GRANT_FETCH} grant_t;

  // Last counter value before the access is abandoned
  localparam logic [7:0] COUNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      state_next;
  grant_t      grant;
  grant_t      grant_next;
  grant_t      last_grant;
  logic [7:0]  counter;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic        byte_q;
  logic        timeout_q;
  logic        dm_req;
  logic        take_grant;
  logic        timeout_hit;
  logic [7:0]  byte_sel;
  logic [31:0] load_data;

  assign dm_req = dm_read | dm_write;

  always_comb begin
    state_next  = state;
    grant_next  = grant;
    take_grant  = 1'b0;
    timeout_hit = 1'b0;
    mem_req     = 1'b0;
    if_ack      = 1'b0;
    dm_ack      = 1'b0;
    err_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (if_req || dm_req) begin
          take_grant = 1'b1;
          state_next = ACCESS;
          // Under contention the side not served last time wins
          if (if_req && dm_req)
            grant_next = (last_grant == GRANT_DATA) ? GRANT_FETCH : GRANT_DATA;
          else if (if_req)
            grant_next = GRANT_FETCH;
          else
            grant_next = GRANT_DATA;
        end
      end
      ACCESS: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          state_next = RESP;
        end else if (counter == COUNT_LAST) begin
          timeout_hit = 1'b1;
          state_next  = RESP;
        end
      end
      RESP: begin
        if_ack      = (grant == GRANT_FETCH);
        dm_ack      = (grant == GRANT_DATA);
        err_timeout = timeout_q;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    case (addr_q[1:0])
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    load_data = byte_q ? {24'b0, byte_sel} : mem_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant      <= GRANT_DATA;
      last_grant <= GRANT_DATA;
      counter    <= 8'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      we_q       <= 1'b0;
      byte_q     <= 1'b0;
      timeout_q  <= 1'b0;
      if_rdata   <= 32'd0;
      dm_rdata   <= 32'd0;
    end else begin
      if (take_grant) begin
        grant      <= grant_next;
        last_grant <= grant_next;
        counter    <= 8'd0;
        timeout_q  <= 1'b0;
        if (grant_next == GRANT_FETCH) begin
          addr_q  <= if_addr;
          wdata_q <= 32'd0;
          we_q    <= 1'b0;
          byte_q  <= 1'b0;
        end else begin
          addr_q  <= dm_addr;
          wdata_q <= dm_wdata;
          we_q    <= dm_write;
          byte_q  <= dm_byte & ~dm_write;
        end
      end
      if (state == ACCESS) begin
        if (mem_ready) begin
          if (grant == GRANT_FETCH) if_rdata <= mem_rdata;
          else if (!we_q)           dm_rdata <= load_data;
        end else begin
          counter <= counter + 8'd1;
          // An abandoned access returns zero; stores leave load data untouched
          if (timeout_hit) begin
            timeout_q <= 1'b1;
            if (grant == GRANT_FETCH) if_rdata <= 32'd0;
            else if (!we_q)           dm_rdata <= 32'd0;
          end
        end
      end
    end
  end

  assign mem_we    = mem_req & we_q;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = wdata_q;
  assign stall     = ~rst & ((if_req & ~if_ack) | (dm_req & ~dm_ack));

endmodule
